// File: rtl/nrisc_ula_mc.sv
// nrisc_ula_mc: multi-cycle NRISC ALU with barrel shift/rotate and optional iterative MUL/DIV.
// Latency: single-cycle ops load the registered result on the sampling edge; MUL/DIV take TAM more edges.
// Backpressure: ULA_busy is high during CALC and start is ignored then. MUL/DIV exist only with NRISC_ULA_MULDIV_EN.
module nrisc_ula_mc #(
    parameter  int TAM = 16,
    localparam int SHW = $clog2(TAM)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ULA_start,
    input  logic [3:0]     ULA_ctrl,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags,
    output logic           ULA_busy,
    output logic           ULA_done,
    output logic           ULA_err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVQ = 4'd9;
    localparam logic [3:0] OP_DIVR = 4'd10;
    localparam logic [3:0] OP_ROTR = 4'd11;
    localparam logic [3:0] OP_ROTL = 4'd12;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         state_q;
    logic [TAM-1:0] out_q;
    logic [2:0]     flags_q;
    logic           err_q;

    // Single-cycle datapath results, computed straight from the ports
    logic [TAM-1:0]   sc_res;
    logic             sc_carry;
    logic             sc_err;
    logic [SHW-1:0]   amt;
    logic [2*TAM-1:0] sh_dbl;

    // Flags are always derived from the value being loaded into ULA_OUT
    function automatic logic [2:0] mk_flags(input logic [TAM-1:0] r, input logic c);
        return {r[TAM-1], (r == '0), c};
    endfunction

    // Combinational single-cycle ALU; anything not handled here reports err with a zero result
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        sh_dbl   = '0;
        amt      = ULA_B[SHW-1:0];
        case (ULA_ctrl)
            OP_ADD: {sc_carry, sc_res} = {1'b0, ULA_A} + {1'b0, ULA_B};
            OP_SUB: begin
                sc_res   = ULA_A - ULA_B;
                sc_carry = (ULA_A < ULA_B);
            end
            OP_AND: sc_res = ULA_A & ULA_B;
            OP_OR:  sc_res = ULA_A | ULA_B;
            OP_XOR: sc_res = ULA_A ^ ULA_B;
            OP_SHR: begin
                sc_res = ULA_A >> amt;
                if (amt != '0)
                    sc_carry = ULA_A[amt - SHW'(1)];
            end
            OP_SHL: begin
                sc_res = ULA_A << amt;
                // TAM is a power of two, so (0 - amt) mod TAM indexes bit TAM-amt
                if (amt != '0)
                    sc_carry = ULA_A[SHW'(0) - amt];
            end
            OP_NOT: sc_res = ~ULA_A;
            OP_ROTR: begin
                sh_dbl = {ULA_A, ULA_A} >> amt;
                sc_res = sh_dbl[TAM-1:0];
            end
            OP_ROTL: begin
                sh_dbl = {ULA_A, ULA_A} << amt;
                sc_res = sh_dbl[2*TAM-1:TAM];
            end
            default: sc_err = 1'b1;
        endcase
    end

`ifdef NRISC_ULA_MULDIV_EN
    logic           is_md;
    logic [TAM-1:0] a_q;
    logic [TAM-1:0] b_q;
    logic [3:0]     op_q;
    logic [TAM-1:0] acc_q;   // product high half / partial remainder
    logic [TAM-1:0] lo_q;    // multiplier bits then product low half / dividend then quotient
    logic [SHW-1:0] cnt_q;
    logic [TAM-1:0] acc_d;
    logic [TAM-1:0] lo_d;
    logic [TAM:0]   mul_sum;
    logic [TAM:0]   div_sh;
    logic [TAM:0]   div_df;
    logic [TAM-1:0] md_res;
    logic           md_carry;

    assign is_md = (ULA_ctrl == OP_MUL) || (ULA_ctrl == OP_DIVQ) || (ULA_ctrl == OP_DIVR);

    // One shift-add (MUL) or restoring shift-subtract (DIV) step; a zero divisor
    // naturally yields an all-ones quotient and leaves the dividend as remainder
    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_sh  = {acc_q, lo_q[TAM-1]};
        div_df  = div_sh - {1'b0, b_q};
        acc_d   = acc_q;
        lo_d    = lo_q;
        if (op_q == OP_MUL) begin
            acc_d = mul_sum[TAM:1];
            lo_d  = {mul_sum[0], lo_q[TAM-1:1]};
        end else if (!div_df[TAM]) begin
            acc_d = div_df[TAM-1:0];
            lo_d  = {lo_q[TAM-2:0], 1'b1};
        end else begin
            acc_d = div_sh[TAM-1:0];
            lo_d  = {lo_q[TAM-2:0], 1'b0};
        end
        md_res   = (op_q == OP_DIVR) ? acc_d : lo_d;
        md_carry = (op_q == OP_MUL) ? (acc_d != '0) : (b_q == '0);
    end
`endif

    // Control FSM with registered result, flags and error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            flags_q <= 3'b010;
            err_q   <= 1'b0;
`ifdef NRISC_ULA_MULDIV_EN
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (ULA_start) begin
`ifdef NRISC_ULA_MULDIV_EN
                        if (is_md) begin
                            state_q <= S_CALC;
                            a_q     <= ULA_A;
                            b_q     <= ULA_B;
                            op_q    <= ULA_ctrl;
                            acc_q   <= '0;
                            lo_q    <= (ULA_ctrl == OP_MUL) ? ULA_B : ULA_A;
                            cnt_q   <= '0;
                        end else
`endif
                        begin
                            state_q <= S_DONE;
                            out_q   <= sc_res;
                            flags_q <= mk_flags(sc_res, sc_carry);
                            err_q   <= sc_err;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
`ifdef NRISC_ULA_MULDIV_EN
                S_CALC: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(TAM - 1)) begin
                        state_q <= S_DONE;
                        out_q   <= md_res;
                        flags_q <= mk_flags(md_res, md_carry);
                        err_q   <= 1'b0;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ULA_OUT   = out_q;
    assign ULA_flags = flags_q;
    assign ULA_err   = err_q;
    assign ULA_busy  = (state_q == S_CALC);
    assign ULA_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_nrisc_ula_mc.sv
// Testbench for nrisc_ula_mc (TAM=16): directed cases plus randomized ops against an arithmetic reference.
// Latency is counted in clock edges from start assertion, including the sampling edge.
// Expectations for opcodes 8-10 follow whether NRISC_ULA_MULDIV_EN is defined.
module tb_nrisc_ula_mc;

    localparam int TAM = 16;
`ifdef NRISC_ULA_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ULA_start = 1'b0;
    logic [3:0]     ULA_ctrl = 4'd0;
    logic [TAM-1:0] ULA_A = '0;
    logic [TAM-1:0] ULA_B = '0;
    logic [TAM-1:0] ULA_OUT;
    logic [2:0]     ULA_flags;
    logic           ULA_busy;
    logic           ULA_done;
    logic           ULA_err;

    int checks = 0;
    int failures = 0;

    nrisc_ula_mc #(.TAM(TAM)) dut (
        .clk       (clk),
        .rst       (rst),
        .ULA_start (ULA_start),
        .ULA_ctrl  (ULA_ctrl),
        .ULA_A     (ULA_A),
        .ULA_B     (ULA_B),
        .ULA_OUT   (ULA_OUT),
        .ULA_flags (ULA_flags),
        .ULA_busy  (ULA_busy),
        .ULA_done  (ULA_done),
        .ULA_err   (ULA_err)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the opcode table
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [2:0] f, output logic e);
        longint unsigned x, y, t;
        int amt;
        logic c;
        x = a; y = b; amt = int'(b[3:0]);
        r = 16'h0; c = 1'b0; e = 1'b0; t = 0;
        case (op)
            4'd0: begin t = x + y; r = t[15:0]; c = (t > 64'd65535); end
            4'd1: begin t = x - y; r = t[15:0]; c = (x < y); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a >> amt; c = (amt != 0) ? a[amt-1] : 1'b0; end
            4'd6: begin t = x << amt; r = t[15:0]; c = (amt != 0) ? t[16] : 1'b0; end
            4'd7: r = ~a;
            4'd11: begin t = (x >> amt) | (x << (16 - amt)); r = t[15:0]; end
            4'd12: begin t = (x << amt) | (x >> (16 - amt)); r = t[15:0]; end
`ifdef NRISC_ULA_MULDIV_EN
            4'd8: begin t = x * y; r = t[15:0]; c = ((t >> 16) != 0); end
            4'd9: begin
                if (y == 0) begin r = 16'hFFFF; c = 1'b1; end
                else begin t = x / y; r = t[15:0]; end
            end
            4'd10: begin
                if (y == 0) begin r = a; c = 1'b1; end
                else begin t = x % y; r = t[15:0]; end
            end
`endif
            default: e = 1'b1;
        endcase
        if (e) begin r = 16'h0; c = 1'b0; end
        f = {r[15], (r == 16'h0), c};
    endfunction

    function automatic bit is_md_op(input logic [3:0] op);
        return MD && (op >= 4'd8) && (op <= 4'd10);
    endfunction

    // Drive one request and wait (bounded) for ULA_done; optionally pokes start while busy
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit poke,
                         output logic [15:0] o_out, output logic [2:0] o_flags, output logic o_err,
                         output int lat, output int bcnt);
        ULA_start = 1'b1; ULA_ctrl = op; ULA_A = a; ULA_B = b;
        lat = 0; bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                ULA_start = 1'b0;
                ULA_A = 16'($urandom);
                ULA_B = 16'($urandom);
            end
            if (ULA_busy) bcnt++;
            if (ULA_done) begin lat = i; break; end
            if (poke && i == 3) begin ULA_start = 1'b1; ULA_ctrl = 4'd0; end
            if (poke && i == 4) ULA_start = 1'b0;
        end
        ULA_start = 1'b0;
        o_out = ULA_OUT; o_flags = ULA_flags; o_err = ULA_err;
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b0;
        #12;
        checks++; if (ULA_OUT !== 16'h0) begin failures++; $display("FAIL reset_out: got %h want 0000", ULA_OUT); end
        checks++; if (ULA_flags !== 3'b010) begin failures++; $display("FAIL reset_flags: got %b want 010", ULA_flags); end
        checks++; if ({ULA_busy, ULA_done, ULA_err} !== 3'b000) begin failures++; $display("FAIL reset_ctl: busy/done/err got %b want 000", {ULA_busy, ULA_done, ULA_err}); end
        rst = 1'b1;
        @(posedge clk); #1;
        // Start a MUL and pull reset in the middle of it
        ULA_start = 1'b1; ULA_ctrl = 4'd8; ULA_A = 16'd100; ULA_B = 16'd3;
        @(posedge clk); #1;
        ULA_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (MD) begin
            checks++; if (ULA_busy !== 1'b1) begin failures++; $display("FAIL reset_pre_busy: got %b want 1", ULA_busy); end
        end
        rst = 1'b0;
        #2;
        checks++; if (ULA_OUT !== 16'h0) begin failures++; $display("FAIL reset_mid_out: got %h want 0000", ULA_OUT); end
        checks++; if (ULA_flags !== 3'b010) begin failures++; $display("FAIL reset_mid_flags: got %b want 010", ULA_flags); end
        checks++; if ({ULA_busy, ULA_done} !== 2'b00) begin failures++; $display("FAIL reset_mid_bd: got %b want 00", {ULA_busy, ULA_done}); end
        #2;
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (ULA_done || ULA_busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL reset_no_done: activity seen %b want 0", seen); end
    endtask

    task automatic test_single();
        logic [3:0]  d_op [5] = '{4'd0, 4'd1, 4'd6, 4'd11, 4'd5};
        logic [15:0] d_a  [5] = '{16'hFFFF, 16'h0003, 16'h8001, 16'h0001, 16'hA5A5};
        logic [15:0] d_b  [5] = '{16'h0001, 16'h0005, 16'h0001, 16'h0004, 16'h0010};
        logic [15:0] d_r  [5] = '{16'h0000, 16'hFFFE, 16'h0002, 16'h1000, 16'hA5A5};
        logic [2:0]  d_f  [5] = '{3'b011, 3'b101, 3'b001, 3'b000, 3'b100};
        logic [15:0] o; logic [2:0] f; logic e; int lat, bc;
        for (int i = 0; i < 5; i++) begin
            issue(d_op[i], d_a[i], d_b[i], 1'b0, o, f, e, lat, bc);
            checks++; if (o !== d_r[i]) begin failures++; $display("FAIL single_out[%0d]: got %h want %h", i, o, d_r[i]); end
            checks++; if (f !== d_f[i]) begin failures++; $display("FAIL single_flags[%0d]: got %b want %b", i, f, d_f[i]); end
            checks++; if (lat != 1) begin failures++; $display("FAIL single_lat[%0d]: got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_muldiv();
`ifdef NRISC_ULA_MULDIV_EN
        logic [3:0]  d_op [5] = '{4'd8, 4'd9, 4'd10, 4'd9, 4'd10};
        logic [15:0] d_a  [5] = '{16'h0100, 16'd100, 16'd100, 16'h1234, 16'h1234};
        logic [15:0] d_b  [5] = '{16'h0100, 16'd7, 16'd7, 16'h0000, 16'h0000};
        logic [15:0] d_r  [5] = '{16'h0000, 16'd14, 16'd2, 16'hFFFF, 16'h1234};
        logic [2:0]  d_f  [5] = '{3'b011, 3'b000, 3'b000, 3'b101, 3'b001};
        int want_lat = TAM + 1, want_bc = TAM;
        logic want_e = 1'b0;
`else
        logic [3:0]  d_op [5] = '{4'd8, 4'd9, 4'd10, 4'd8, 4'd10};
        logic [15:0] d_a  [5] = '{16'h0100, 16'd100, 16'd100, 16'h1234, 16'h1234};
        logic [15:0] d_b  [5] = '{16'h0100, 16'd7, 16'd7, 16'h0000, 16'h0000};
        logic [15:0] d_r  [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [2:0]  d_f  [5] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
        int want_lat = 1, want_bc = 0;
        logic want_e = 1'b1;
`endif
        logic [15:0] o; logic [2:0] f; logic e; int lat, bc;
        for (int i = 0; i < 5; i++) begin
            issue(d_op[i], d_a[i], d_b[i], (i == 0), o, f, e, lat, bc);
            checks++; if (o !== d_r[i]) begin failures++; $display("FAIL md_out[%0d]: got %h want %h", i, o, d_r[i]); end
            checks++; if (f !== d_f[i]) begin failures++; $display("FAIL md_flags[%0d]: got %b want %b", i, f, d_f[i]); end
            checks++; if (e !== want_e) begin failures++; $display("FAIL md_err[%0d]: got %b want %b", i, e, want_e); end
            checks++; if (lat != want_lat) begin failures++; $display("FAIL md_lat[%0d]: got %0d want %0d", i, lat, want_lat); end
            checks++; if (bc != want_bc) begin failures++; $display("FAIL md_busy[%0d]: got %0d want %0d", i, bc, want_bc); end
        end
    endtask

    task automatic test_err();
        logic [15:0] o; logic [2:0] f; logic e; int lat, bc;
        issue(4'd15, 16'h1234, 16'h5678, 1'b0, o, f, e, lat, bc);
        checks++; if ({o, f, e} !== {16'h0, 3'b010, 1'b1}) begin failures++; $display("FAIL err_op15: got out=%h flags=%b err=%b want 0000/010/1", o, f, e); end
        issue(4'd0, 16'h0002, 16'h0003, 1'b0, o, f, e, lat, bc);
        checks++; if ({o, f, e} !== {16'h0005, 3'b000, 1'b0}) begin failures++; $display("FAIL err_clear: got out=%h flags=%b err=%b want 0005/000/0", o, f, e); end
    endtask

    task automatic test_hold();
        logic [15:0] o; logic [2:0] f; logic e; int lat, bc;
        bit bad = 1'b0;
        issue(4'd4, 16'h0F0F, 16'hFF00, 1'b0, o, f, e, lat, bc);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ULA_done || ULA_OUT !== 16'hF00F || ULA_flags !== 3'b100) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL hold: got out=%h flags=%b done=%b want F00F/100/0", ULA_OUT, ULA_flags, ULA_done); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sc_ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12};
        logic [15:0] o, r, a, b; logic [2:0] f, wf; logic e, we; int lat, bc;
        bit gap = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            op = sc_ops[$urandom_range(0, 9)];
            a = 16'($urandom); b = 16'($urandom);
            model(op, a, b, r, wf, we);
            issue(op, a, b, 1'b0, o, f, e, lat, bc);
            if (lat != 1) gap = 1'b1;
            checks++; if ({o, f} !== {r, wf}) begin failures++; $display("FAIL b2b[%0d] op%0d: got %h/%b want %h/%b", i, op, o, f, r, wf); end
        end
        checks++; if (gap) begin failures++; $display("FAIL b2b_done_gap: got gap %b want 0", gap); end
    endtask

    task automatic test_random();
        logic [15:0] o, r, a, b; logic [2:0] f, wf; logic e, we; logic [3:0] op; int lat, bc;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            a = 16'($urandom); b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = 16'h0;
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 255));
            model(op, a, b, r, wf, we);
            issue(op, a, b, 1'b0, o, f, e, lat, bc);
            checks++; if (o !== r) begin failures++; $display("FAIL rnd_out[%0d] op%0d a=%h b=%h: got %h want %h", i, op, a, b, o, r); end
            checks++; if (f !== wf) begin failures++; $display("FAIL rnd_flags[%0d] op%0d a=%h b=%h: got %b want %b", i, op, a, b, f, wf); end
            checks++; if (e !== we) begin failures++; $display("FAIL rnd_err[%0d] op%0d: got %b want %b", i, op, e, we); end
            checks++; if (lat != (is_md_op(op) ? TAM + 1 : 1)) begin failures++; $display("FAIL rnd_lat[%0d] op%0d: got %0d want %0d", i, op, lat, is_md_op(op) ? TAM + 1 : 1); end
            checks++; if (bc != (is_md_op(op) ? TAM : 0)) begin failures++; $display("FAIL rnd_busy[%0d] op%0d: got %0d want %0d", i, op, bc, is_md_op(op) ? TAM : 0); end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_muldiv();
        test_err();
        test_hold();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nrisc_ula_mc.md
# nrisc_ula_mc

Multi-cycle, parametrised successor of the NRISC ALU. It registers its operands and results and adds a barrel shifter and rotate by amount. Where compiled in, it also adds iterative unsigned multiply and divide, sequenced by a start/busy/done handshake. It sits between the register file read ports and the write-back mux. The control unit stalls on `ULA_busy`.

## Interface
- `TAM`, 16: operand/result width. Must be ≥4 and a power of two.
- `SHW`, `$clog2(TAM)`: shift-amount width. It is derived; never override it.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `ULA_start` input 1: operation request. Sampled only when `ULA_busy`=0.
- `ULA_ctrl` input 4: opcode.
- `ULA_A` input TAM: operand A.
- `ULA_B` input TAM: operand B. For shifts and rotates, `B[SHW-1:0]` is the amount.
- `ULA_OUT` output TAM: registered result.
- `ULA_flags` output 3: registered `{minus, zero, carry}`.
- `ULA_busy` output 1: high while a multi-cycle operation runs.
- `ULA_done` output 1: one-cycle pulse when `ULA_OUT`/`ULA_flags` update.
- `ULA_err` output 1: registered; set by a reserved or compiled-out opcode.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHR: logical right by amt.
  - 6 SHL: left by amt.
  - 7 NOT: ~A.
  - 8 MUL: low TAM bits of A*B, unsigned.
  - 9 DIVQ: A/B, unsigned.
  - 10 DIVR: A%B, unsigned.
  - 11 ROTR by amt.
  - 12 ROTL by amt.
  - 13–15: reserved.
- FSM states: IDLE, CALC, DONE.
  - IDLE or DONE with `ULA_start`=1 and a single-cycle opcode (0–7, 11–15): go to DONE, loading result, flags and err.
  - IDLE or DONE with `ULA_start`=1 and opcode 8–10: go to CALC. Latch A, B and op. Clear the iteration counter.
  - CALC: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. After TAM steps, go to DONE and load result, flags and err.
  - DONE with no start: go to IDLE.
- `ULA_busy` = (state==CALC). `ULA_done` = (state==DONE).
- `ULA_start` is ignored while in CALC. No queuing.
- Carry:
  - ADD: carry-out of bit TAM−1.
  - SUB: borrow (A<B unsigned).
  - SHR/SHL: last bit shifted out. 0 when amt=0.
  - MUL: 1 if the high half of the 2·TAM product is nonzero.
  - DIVQ/DIVR: 1 on divide-by-zero.
  - All other ops: 0.
- minus = `ULA_OUT[TAM-1]` for every op. zero = (`ULA_OUT`==0) for every op.
- Divide-by-zero: DIVQ returns all ones, DIVR returns A, carry=1. Full TAM-step latency regardless.
- Reserved opcode: `ULA_OUT`=0, flags=`{0,1,0}`, `ULA_err`=1. `ULA_err` is cleared by the next accepted non-erroring op.
- Outputs hold their values from DONE until the next load. No update occurs without a pulse on `ULA_done`.

## Timing
- Reset (async assert, `rst`=0) forces:
  - state=IDLE.
  - `ULA_OUT`=0.
  - `ULA_flags`=3'b010.
  - `ULA_busy`=0, `ULA_done`=0, `ULA_err`=0.
  - The iteration counter and internal operand registers are cleared.
- Reset mid-CALC aborts the operation. No `ULA_done` is produced.
- Reset deassertion must be synchronised externally to `clk`.
- Latency, with start sampled at edge k:
  - Single-cycle op: outputs valid and `ULA_done`=1 after edge k+1.
  - MUL/DIV: `ULA_busy`=1 after edge k+1 through edge k+TAM. Outputs valid and `ULA_done`=1 after edge k+TAM+1.
- Back-to-back: a start asserted during DONE is accepted. With single-cycle ops, that gives one result per cycle with `ULA_done` held high continuously.
- Operands must be stable only in the start cycle. Changes to `ULA_A`/`ULA_B` during CALC have no effect.

## Configuration
- `NRISC_ULA_MULDIV_EN` defined: opcodes 8–10 are implemented as above, including the CALC state and the iteration datapath.
- Not defined: opcodes 8–10 are treated as reserved. They complete in one cycle with `ULA_OUT`=0, `ULA_err`=1 and `ULA_busy` never asserted. The CALC datapath is not synthesised.

## Test plan
- Reset: hold `rst`=0 mid-MUL. Required: `ULA_OUT`=0, flags=010, busy=0, and no done after release.
- ADD 16'hFFFF + 16'h0001 → OUT=0000, flags=011, done after 1 edge. SUB 16'h0003 − 16'h0005 → OUT=FFFE, flags=101.
- SHL A=16'h8001, amt=1 → OUT=0002, carry=1. ROTR A=16'h0001, amt=4 → OUT=1000, carry=0. SHR with amt=0 → OUT=A, carry=0.
- MUL 16'h0100 × 16'h0100 → OUT=0000, flags=011. Busy is high for 16 cycles, and done follows exactly 17 edges after start. A second start during busy is ignored.
- DIVQ 16'd100/16'd7 → 14. DIVR → 2. DIVQ by 0 → FFFF with carry=1. DIVR by 0 → A.
- Opcode 15 → OUT=0, flags=010, err=1. A following ADD clears err. Without `NRISC_ULA_MULDIV_EN`, opcode 8 → err=1 with busy never high.
